// File: rtl/memseq_pkg.sv
// Shared types and widths for the memory-access sequencer.
// MEMSEQ_STORE_VERIFY_EN adds the VERIFY state used for store read-back checking.
package memseq_pkg;

  localparam int PC_W       = 8;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int RD_LAT_MAX = 4;
  // Counter must be able to hold RD_LAT_MAX itself, not just RD_LAT_MAX-1.
  localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
`ifdef MEMSEQ_STORE_VERIFY_EN
    ST_RESP   = 2'd2,
    ST_VERIFY = 2'd3
`else
    ST_RESP   = 2'd2
`endif
  } state_t;

  // The reserved encoding 3 behaves as a load.
  function automatic op_t decode_op(input logic [1:0] raw);
    if (raw == 2'd3) begin
      return OP_LOAD;
    end
    return op_t'(raw);
  endfunction

endpackage

// File: rtl/memseq_if.sv
// Bundle of request, memory and response signals around the sequencer.
// slave = sequencer, master = pipeline control, mem = memory-access block.
interface memseq_if;
  import memseq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [PC_W-1:0]   req_pc;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic [PC_W-1:0]   pc;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] q;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              verify_err;

  modport slave (
    input  req_valid, req_op, req_pc, req_addr, req_wdata, ir, q,
    output req_ready, pc, address, data, wren, rsp_valid, rsp_data, verify_err
  );

  modport master (
    output req_valid, req_op, req_pc, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, verify_err
  );

  modport mem (
    input  pc, address, data, wren,
    output ir, q
  );

endinterface

// File: rtl/memseq.sv
// Memory-access sequencer: one fetch/load/store in flight, registered memory-side
// outputs, single-cycle response. MEMSEQ_STORE_VERIFY_EN enables store read-back.
module memseq #(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  memseq_if.slave  bus
);
  import memseq_pkg::*;

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  op_t               r_op, w_op;
  op_t               w_req_op;
  logic              r_ready, w_ready;
  logic [PC_W-1:0]   r_pc, w_pc;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_data, w_data;
  logic              r_wren, w_wren;
  logic              r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data;
`ifdef MEMSEQ_STORE_VERIFY_EN
  logic              r_verify_err, w_verify_err;
`endif

  assign w_req_op = decode_op(bus.req_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_op         <= OP_FETCH;
      r_ready      <= 1'b0;
      r_pc         <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_wren       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
`ifdef MEMSEQ_STORE_VERIFY_EN
      r_verify_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_op         <= w_op;
      r_ready      <= w_ready;
      r_pc         <= w_pc;
      r_addr       <= w_addr;
      r_data       <= w_data;
      r_wren       <= w_wren;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_data   <= w_rsp_data;
`ifdef MEMSEQ_STORE_VERIFY_EN
      r_verify_err <= w_verify_err;
`endif
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_op         = r_op;
    w_ready      = r_ready;
    w_pc         = r_pc;
    w_addr       = r_addr;
    w_data       = r_data;
    w_wren       = r_wren;
    w_rsp_valid  = r_rsp_valid;
    w_rsp_data   = r_rsp_data;
`ifdef MEMSEQ_STORE_VERIFY_EN
    w_verify_err = r_verify_err;
`endif

    case (r_state)
      ST_IDLE: begin
        // Ready is low only on the first cycle after reset.
        if (!r_ready) begin
          w_ready = 1'b1;
        end else if (bus.req_valid) begin
          w_ready = 1'b0;
          w_op    = w_req_op;
          w_cnt   = CNT_W'(RD_LAT);
          w_state = ST_WAIT;
          case (w_req_op)
            OP_FETCH: w_pc = bus.req_pc;
            OP_STORE: begin
              w_addr = bus.req_addr;
              w_data = bus.req_wdata;
              w_wren = 1'b1;
            end
            default:  w_addr = bus.req_addr;
          endcase
        end
      end

      ST_WAIT: begin
        w_wren = 1'b0;
        if (r_cnt != '0) begin
          w_cnt = r_cnt - CNT_W'(1);
        end else begin
`ifdef MEMSEQ_STORE_VERIFY_EN
          if (r_op == OP_STORE) begin
            w_cnt   = CNT_W'(RD_LAT);
            w_state = ST_VERIFY;
          end else begin
            w_rsp_valid = 1'b1;
            w_rsp_data  = (r_op == OP_FETCH) ? bus.ir : bus.q;
            w_state     = ST_RESP;
          end
`else
          w_rsp_valid = 1'b1;
          case (r_op)
            OP_FETCH: w_rsp_data = bus.ir;
            OP_STORE: w_rsp_data = r_data;
            default:  w_rsp_data = bus.q;
          endcase
          w_state = ST_RESP;
`endif
        end
      end

      ST_RESP: begin
        w_rsp_valid = 1'b0;
        w_ready     = 1'b1;
        w_state     = ST_IDLE;
      end

`ifdef MEMSEQ_STORE_VERIFY_EN
      // Address was re-sampled after the write; compare one edge before responding.
      ST_VERIFY: begin
        if (r_cnt == '0) begin
          w_rsp_valid = 1'b1;
          w_rsp_data  = r_data;
          w_state     = ST_RESP;
        end else begin
          if ((r_cnt == CNT_W'(1)) && (bus.q != r_data)) begin
            w_verify_err = 1'b1;
          end
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
`endif

      default: w_state = ST_IDLE;
    endcase
  end

  assign bus.req_ready = r_ready;
  assign bus.pc        = r_pc;
  assign bus.address   = r_addr;
  assign bus.data      = r_data;
  assign bus.wren      = r_wren;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
`ifdef MEMSEQ_STORE_VERIFY_EN
  assign bus.verify_err = r_verify_err;
`else
  assign bus.verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_memseq.sv
// Scoreboard bench for memseq: a predictor pushes expected responses on accept,
// a monitor pops and checks them; memory is a behavioural RD_LAT-deep model.
module tb_memseq;
  import memseq_pkg::*;

`ifdef MEMSEQ_STORE_VERIFY_EN
  localparam int RD_LAT = 2;
  localparam bit VERIFY = 1'b1;
`else
  localparam int RD_LAT = 1;
  localparam bit VERIFY = 1'b0;
`endif
  localparam int LAT_RD = RD_LAT + 1;
  localparam int LAT_ST = VERIFY ? (2 * RD_LAT + 2) : (RD_LAT + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memseq_if bus();

  memseq #(.RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h1111_1111 * 32'(i + 1);
  endfunction

  // ---------------- memory block model ----------------
  logic [31:0] mem [256];
  logic [31:0] ir_pipe [RD_LAT];
  logic [31:0] q_pipe [RD_LAT];
  bit mem_loaded = 1'b0;
  bit corrupt = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        ir_pipe[i] <= ir_pipe[i-1];
        q_pipe[i]  <= q_pipe[i-1];
      end
      ir_pipe[0] <= mem[bus.pc];
      q_pipe[0]  <= mem[bus.address];
      if (bus.wren) mem[bus.address] <= bus.data;
    end
  end
  assign bus.ir = ir_pipe[RD_LAT-1];
  assign bus.q  = corrupt ? 32'hDEAD_BEEF : q_pipe[RD_LAT-1];

  // ---------------- reference model / predictor ----------------
  typedef struct {
    logic [31:0] data;
    int          due;
    logic [1:0]  op;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ref_mem [256];
  bit ref_loaded = 1'b0;
  logic [7:0]  exp_pc = '0, exp_addr = '0;
  logic [31:0] exp_data = '0;
  bit          pend_store = 1'b0;
  logic [7:0]  pend_addr;
  logic [31:0] pend_data;
  int          stores_committed = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!ref_loaded) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      ref_loaded = 1'b1;
    end
    if (!rst_n) begin
      exp_q.delete();
      pend_store = 1'b0;
      exp_pc = '0;
      exp_addr = '0;
      exp_data = '0;
    end else begin
      // A store that survived its write cycle is now part of memory.
      if (pend_store) begin
        ref_mem[pend_addr] = pend_data;
        stores_committed++;
        pend_store = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) begin
        e.op = bus.req_op;
        case (bus.req_op)
          2'd0: begin
            exp_pc = bus.req_pc;
            e.data = ref_mem[bus.req_pc];
            e.due  = cyc + 1 + LAT_RD;
          end
          2'd2: begin
            exp_addr   = bus.req_addr;
            exp_data   = bus.req_wdata;
            e.data     = bus.req_wdata;
            e.due      = cyc + 1 + LAT_ST;
            pend_store = 1'b1;
            pend_addr  = bus.req_addr;
            pend_data  = bus.req_wdata;
          end
          default: begin
            exp_addr = bus.req_addr;
            e.data   = ref_mem[bus.req_addr];
            e.due    = cyc + 1 + LAT_RD;
          end
        endcase
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  int wren_cycles = 0;
  int rsp_cyc_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_rsp: got rsp_data %08h with no request outstanding (cycle %0d)",
                 bus.rsp_data, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] rsp op=%0d data=%08h cycle=%0d", e.op, bus.rsp_data, cyc);
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_cycle", 32'(cyc), 32'(e.due));
        check("pc_hold", 32'(bus.pc), 32'(exp_pc));
        check("addr_hold", 32'(bus.address), 32'(exp_addr));
        rsp_cyc_q.push_back(cyc);
      end
    end
    if (rst_n && bus.wren) begin
      wren_cycles++;
      check("wren_addr", 32'(bus.address), 32'(exp_addr));
      check("wren_data", bus.data, exp_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] op, input logic [7:0] p, input logic [7:0] a,
                       input logic [31:0] w);
    bus.req_op    = op;
    bus.req_pc    = p;
    bus.req_addr  = a;
    bus.req_wdata = w;
    bus.req_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.req_ready) break;
      if (t == 59) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: got req_ready 0 for 60 cycles expected 1");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      if (t == 99) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d responses outstanding expected 0", exp_q.size());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_pc    = 8'h00;
    bus.req_addr  = 8'h00;
    bus.req_wdata = '0;

    // Reset held 3 cycles with a request pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_pc", 32'(bus.pc), 0);
    check("rst_address", 32'(bus.address), 0);
    check("rst_data", bus.data, 0);
    check("rst_wren", 32'(bus.wren), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_verify_err", 32'(bus.verify_err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("ready_one_edge", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    check("first_accept", 32'(exp_q.size()), 1);
    drain();

    // Store then load at 0x01; pc must stay 0x00.
    issue(2'd2, 8'h5A, 8'h01, 32'h1111_1111);
    drain();
    check("store_wren_once", 32'(wren_cycles), 32'(stores_committed));
    issue(2'd1, 8'hA5, 8'h01, 32'h0);
    drain();

    // Back-to-back fetches with req_valid held.
    issue(2'd0, 8'h02, 8'h00, 32'h0);
    issue(2'd0, 8'h03, 8'h00, 32'h0);
    drain();
    check("b2b_spacing", 32'(rsp_cyc_q[rsp_cyc_q.size()-1] - rsp_cyc_q[rsp_cyc_q.size()-2]),
          32'(RD_LAT + 3));

    // Reset during the write cycle of a store.
    issue(2'd2, 8'h00, 8'h07, 32'hCAFE_F00D);
    bus.req_valid = 1'b0;
    check("wren_before_abort", 32'(bus.wren), 1);
    #1 rst_n = 1'b0;
    #1 check("wren_async_drop", 32'(bus.wren), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);
    issue(2'd1, 8'h00, 8'h07, 32'h0);
    drain();

    // Store read-back corrupted, then a clean store, then reset.
    corrupt = 1'b1;
    issue(2'd2, 8'h00, 8'h20, 32'h1111_1111);
    drain();
    corrupt = 1'b0;
    check("verify_err_bad", 32'(bus.verify_err), 32'(VERIFY));
    issue(2'd2, 8'h00, 8'h21, 32'h2222_2222);
    drain();
    check("verify_err_sticky", 32'(bus.verify_err), 32'(VERIFY));
    issue(2'd1, 8'h00, 8'h20, 32'h0);
    drain();
    reset_pulse();
    check("verify_err_cleared", 32'(bus.verify_err), 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
            $urandom);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
    end
    drain();
    idle(5);

    check("wren_count", 32'(wren_cycles), 32'(stores_committed));
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within 1 ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memseq.md
# memseq

Memory-access sequencer: the initiator side of the core's instruction/data memory port. It accepts one fetch, load or store request at a time from the pipeline control, drives the memory block's `pc`/`address`/`data`/`wren` inputs, waits out the synchronous read latency, and returns the captured `ir` (fetch) or `q` (load) word as a single-cycle response. It sits between the control FSM and the memory-access block, and is the only driver of that block's request-side inputs.

## Interface
- `RD_LAT`, default 1: number of clock edges from the memory sampling `pc`/`address` to `ir`/`q` becoming valid. Legal range is 1..4.
- `clk` in 1: single clock. Everything is posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle. A request is accepted on a posedge where `req_valid && req_ready`.
- `req_op` in 2: 0 = FETCH, 1 = LOAD, 2 = STORE. 3 is reserved and treated as LOAD.
- `req_pc` in 8: fetch address.
- `req_addr` in 8: load/store address.
- `req_wdata` in 32: store data.
- `pc` out 8: to memory, instruction address.
- `address` out 8: to memory, data address.
- `data` out 32: to memory, write data.
- `wren` out 1: to memory, write enable.
- `ir` in 32: from memory, instruction word.
- `q` in 32: from memory, data word.
- `rsp_valid` out 1: one-cycle response pulse. No backpressure.
- `rsp_data` out 32: `ir` for FETCH, `q` for LOAD, `req_wdata` for STORE.
- `verify_err` out 1: sticky store-readback mismatch flag.

## Operation
- FSM states: IDLE, WAIT, RESP, and VERIFY (VERIFY exists only with the macro).
- **Reset.**
  - State goes to IDLE.
  - `req_ready`, `pc`, `address`, `data`, `wren`, `rsp_valid`, `rsp_data` and `verify_err` all reset to 0.
  - Every output is registered.
- **Accept** (IDLE, edge E0):
  - FETCH loads `pc` ← `req_pc`; `address` and `data` hold.
  - LOAD loads `address` ← `req_addr`; `pc` holds.
  - STORE loads `address` ← `req_addr`, `data` ← `req_wdata`, and sets `wren` ← 1.
  - `req_ready` ← 0; state → WAIT; latency counter ← RD_LAT.
- **WAIT.**
  - `wren` is cleared at E1, so a store writes exactly once.
  - The counter decrements each edge.
  - On the edge where the counter reaches 0, `rsp_data` captures the selected source and `rsp_valid` ← 1; state → RESP.
- **RESP.**
  - Lasts one cycle.
  - At the next edge `rsp_valid` ← 0 and `req_ready` ← 1; state → IDLE.
- Only one request is in flight at a time. `req_*` inputs are ignored outside the accept edge.
- `req_valid` held high while busy is accepted at the first edge where `req_ready` = 1. No request is dropped or duplicated.
- Reset asserted mid-operation aborts immediately: `wren` drops asynchronously and no response is issued.

## Timing
- Read response: `rsp_valid` is high during the cycle following edge E(RD_LAT+1).
  - Accept-to-response latency = RD_LAT+1 edges.
  - Request throughput = one per RD_LAT+3 cycles.
- `wren` is high for exactly the cycle E0→E1.
- `req_ready` first rises at the first posedge after `rst_n` deasserts.

## Configuration
- Macro: `MEMSEQ_STORE_VERIFY_EN`.
- **Defined:** a STORE does not go to RESP from WAIT; it goes to VERIFY.
  - `address` holds its value while `wren` is low.
  - VERIFY waits RD_LAT further edges, then compares `q` against the latched `data`.
  - A mismatch sets `verify_err` ← 1, which stays set until reset.
  - `rsp_valid` follows one edge after the compare, so STORE latency = 2·RD_LAT+2 edges.
- **Undefined:** STORE timing is identical to LOAD. The `verify_err` port remains present and is tied 0.

## Structure
- Package `memseq_pkg` holds:
  - the `op_t` enum (FETCH/LOAD/STORE);
  - the `state_t` enum;
  - localparams `PC_W`=8, `ADDR_W`=8, `DATA_W`=32;
  - the counter width, derived from the RD_LAT maximum.
- Single module. The latency countdown is inline; no sub-module is warranted.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `req_valid`=1 → all outputs 0. `req_ready`=1 one edge after release; first request accepted on the next edge.
- **Fetch:** memory preloaded with mem[0x00]=0x1111_1111, RD_LAT=1; FETCH `req_pc`=0x00 → `pc`=0x00 from E0, `wren`=0, `rsp_valid` pulse after E2 with `rsp_data`=0x1111_1111.
- **Store then load:** STORE addr 0x01, data 0x1111_1111 → `wren` high for exactly 1 cycle. Then LOAD 0x01 → `rsp_data`=0x1111_1111; `pc` unchanged throughout.
- **Back-to-back:** `req_valid` held for two FETCHes (0x02, 0x03) → two responses in order, spaced RD_LAT+3 cycles apart; no extra responses.
- **Reset mid-store:** pull `rst_n` low during the `wren` cycle → `wren` drops immediately; `rsp_valid` never asserts; no write is observed after release.
- **Macro defined:** bench forces memory read-back to 0xDEAD_BEEF for a STORE of 0x1111_1111 → `verify_err`=1, still set after a later good store, cleared only by reset. With RD_LAT=2, LOAD latency = 3 edges.
